// File: rtl/census_3x3_if.sv
// census_3x3_if: pixel-stream input and census-stream output of census_3x3.
// master = pixel source / census consumer side, slave = the census block.
// With CENSUS_CENTER_EN defined the bundle also carries out_pix.
interface census_3x3_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_val;
  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic             pix_valid;
  logic [7:0]       census;
  logic [9:0]       out_x;
  logic [9:0]       out_y;
  logic             out_valid;
  logic             frame_done;
`ifdef CENSUS_CENTER_EN
  logic [PIX_W-1:0] out_pix;

  modport master (
    output pix_val, pix_x, pix_y, pix_valid,
    input  census, out_x, out_y, out_valid, frame_done, out_pix
  );

  modport slave (
    input  pix_val, pix_x, pix_y, pix_valid,
    output census, out_x, out_y, out_valid, frame_done, out_pix
  );
`else
  modport master (
    output pix_val, pix_x, pix_y, pix_valid,
    input  census, out_x, out_y, out_valid, frame_done
  );

  modport slave (
    input  pix_val, pix_x, pix_y, pix_valid,
    output census, out_x, out_y, out_valid, frame_done
  );
`endif
endinterface

// File: rtl/census_3x3.sv
// census_3x3: streaming 3x3 census transform over a raster-order pixel stream.
// Two line buffers (rows y-1, y-2) and a 3x3 shift window feed a compare
// stage; fixed two-cycle latency, no backpressure.
// Optional feature macro CENSUS_CENTER_EN: also drives bus.out_pix with the
// raw centre pixel aligned with out_valid.
module census_3x3 #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int PIX_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  census_3x3_if.slave bus
);
  localparam int         AW     = $clog2(IMG_W);
  localparam logic [9:0] X_END  = 10'(IMG_W);
  localparam logic [9:0] Y_END  = 10'(IMG_H);
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  typedef logic [PIX_W-1:0] pix_t;

  // Line buffers: lb0 holds row y-1, lb1 holds row y-2, indexed by column
  pix_t lb0_q [IMG_W];
  pix_t lb1_q [IMG_W];

  // Window: [row][col], row 0 = top, col 0 = left (oldest column)
  pix_t win_q [3][3];
  pix_t win_d [3][3];

  logic       armed_q, armed_d;
  logic       s1_vld_q, s1_vld_d;
  logic       s1_last_q, s1_last_d;
  logic [9:0] s1_x_q, s1_x_d;
  logic [9:0] s1_y_q, s1_y_d;

  logic [7:0] census_q, census_d;
  logic [9:0] out_x_q;
  logic [9:0] out_y_q;
  logic       out_valid_q;
  logic       frame_done_q;

  logic          acc_s;
  logic          emit_s;
  logic          origin_s;
  logic          last_s;
  logic [AW-1:0] addr_s;
  pix_t          lb0_rd_s;
  pix_t          lb1_rd_s;

  // One census bit: neighbour strictly darker than the centre
  function automatic logic lt_f(input pix_t nb, input pix_t ctr);
    return (nb < ctr);
  endfunction

  // Decode the incoming strobe and read both line buffers at the column
  always_comb begin
    acc_s    = bus.pix_valid && (bus.pix_x < X_END) && (bus.pix_y < Y_END);
    addr_s   = bus.pix_x[AW-1:0];
    lb0_rd_s = lb0_q[addr_s];
    lb1_rd_s = lb1_q[addr_s];
    origin_s = (bus.pix_x == 10'd0) && (bus.pix_y == 10'd0);
    last_s   = (bus.pix_x == X_LAST) && (bus.pix_y == Y_LAST);
    emit_s   = acc_s && armed_q && (bus.pix_x >= 10'd2) && (bus.pix_y >= 10'd2);
  end

  // Stage-1 next state: window shift, centre coordinates, arming
  always_comb begin
    win_d     = win_q;
    armed_d   = armed_q;
    s1_x_d    = s1_x_q;
    s1_y_d    = s1_y_q;
    s1_vld_d  = emit_s;
    s1_last_d = emit_s && last_s;
    if (acc_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd_s;
      win_d[1][2] = lb0_rd_s;
      win_d[2][2] = bus.pix_val;
      s1_x_d      = bus.pix_x - 10'd1;
      s1_y_d      = bus.pix_y - 10'd1;
      if (origin_s) begin
        armed_d = 1'b1;
      end else begin
        armed_d = armed_q;
      end
    end else begin
      win_d   = win_q;
      armed_d = armed_q;
    end
  end

  // Stage-2 compare: eight neighbours against the centre, TL..BR = bit7..bit0
  always_comb begin
    census_d = {lt_f(win_q[0][0], win_q[1][1]),
                lt_f(win_q[0][1], win_q[1][1]),
                lt_f(win_q[0][2], win_q[1][1]),
                lt_f(win_q[1][0], win_q[1][1]),
                lt_f(win_q[1][2], win_q[1][1]),
                lt_f(win_q[2][0], win_q[1][1]),
                lt_f(win_q[2][1], win_q[1][1]),
                lt_f(win_q[2][2], win_q[1][1])};
  end

  // Line buffers: read-before-write shift of each column's row history
  always_ff @(posedge clk) begin
    if (acc_s) begin
      lb1_q[addr_s] <= lb0_rd_s;
      lb0_q[addr_s] <= bus.pix_val;
    end
  end

  // Stage-1 registers: window, arming flag and the pending-centre tag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= {PIX_W{1'b0}};
        end
      end
      armed_q   <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_x_q    <= 10'd0;
      s1_y_q    <= 10'd0;
    end else begin
      win_q     <= win_d;
      armed_q   <= armed_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
    end
  end

  // Stage-2 output registers; payload holds between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      census_q     <= 8'd0;
      out_x_q      <= 10'd0;
      out_y_q      <= 10'd0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= s1_vld_q;
      frame_done_q <= s1_last_q;
      if (s1_vld_q) begin
        census_q <= census_d;
        out_x_q  <= s1_x_q;
        out_y_q  <= s1_y_q;
      end
    end
  end

`ifdef CENSUS_CENTER_EN
  pix_t out_pix_q;

  // Raw centre pixel, registered alongside the census signature
  always_ff @(posedge clk) begin
    if (reset) begin
      out_pix_q <= {PIX_W{1'b0}};
    end else if (s1_vld_q) begin
      out_pix_q <= win_q[1][1];
    end
  end

  assign bus.out_pix = out_pix_q;
`endif

  assign bus.census     = census_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_census_3x3.sv
// tb_census_3x3: self-checking bench for census_3x3.
// A monitor keeps a 2-D image model of every accepted pixel and derives the
// expected census for each centre directly from the image; directed tables
// and sequences cover ramps, full-frame count, rate changes and reset.
`timescale 1ns/1ps
module tb_census_3x3;
  localparam int W = 320;
  localparam int H = 240;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  census_3x3_if #(.PIX_W(8)) bus ();

  census_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int unsigned seed;

  typedef struct { int due; int x; int y; int cen; bit chk_c; bit last; int pix; } exp_t;
  typedef struct { int c; int x; int y; } cap_t;
  typedef struct { int mode; int y0; int y1; int px; int py; int exp_c; } vec_t;

  exp_t exp_q[$];
  cap_t cap_q[$];
  cap_t cap_a[$];
  cap_t cap_b[$];
  int   img [H][W];
  bit   vld [H][W];
  bit   armed_m = 1'b0;
  int   n_fd = 0;
  int   fd_x = -1;
  int   fd_y = -1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int pixf(input int mode, input int x, input int y);
    int unsigned h;
    case (mode)
      0: return 128;
      1: return x & 255;
      2: return y & 255;
      default: begin
        h = (int'(x) * 73856093) ^ (int'(y) * 19349663) ^ seed;
        h = h ^ (h >> 13);
        h = h * 32'h5bd1e995;
        h = h ^ (h >> 15);
        return int'(h & 32'd255);
      end
    endcase
  endfunction

  // Reference census straight from the image: bit7..bit0 = TL,T,TR,L,R,BL,B,BR
  function automatic int census_ref(input int x, input int y);
    int dys[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dxs[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int r = 0;
    for (int k = 0; k < 8; k++)
      r = (r << 1) | ((img[y + dys[k]][x + dxs[k]] < img[y][x]) ? 1 : 0);
    return r;
  endfunction

  function automatic bit window_known(input int x, input int y);
    bit ok = 1'b1;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!vld[y + dy][x + dx]) ok = 1'b0;
    return ok;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard: check outputs due now, then model the pending input
  initial begin
    exp_t e;
    int px, py;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("out_valid_due", int'(bus.out_valid), 1);
        if (bus.out_valid) begin
          chk("out_x", int'(bus.out_x), e.x);
          chk("out_y", int'(bus.out_y), e.y);
          chk("frame_done", int'(bus.frame_done), int'(e.last));
          if (e.chk_c) chk("census", int'(bus.census), e.cen);
`ifdef CENSUS_CENTER_EN
          if (e.chk_c) chk("out_pix", int'(bus.out_pix), e.pix);
`endif
        end
      end else begin
        chk("idle_out_valid", int'(bus.out_valid), 0);
        chk("idle_frame_done", int'(bus.frame_done), 0);
      end
      if (bus.out_valid) cap_q.push_back('{int'(bus.census), int'(bus.out_x), int'(bus.out_y)});
      if (bus.frame_done) begin
        n_fd++;
        fd_x = int'(bus.out_x);
        fd_y = int'(bus.out_y);
      end
      px = int'(bus.pix_x);
      py = int'(bus.pix_y);
      if (reset) begin
        exp_q.delete();
        armed_m = 1'b0;
      end else if (bus.pix_valid && px < W && py < H) begin
        if (px == 0 && py == 0) begin
          for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) vld[yy][xx] = 1'b0;
        end
        img[py][px] = int'(bus.pix_val);
        vld[py][px] = 1'b1;
        if (armed_m && px >= 2 && py >= 2) begin
          e.due   = cyc + 2;
          e.x     = px - 1;
          e.y     = py - 1;
          e.chk_c = window_known(px - 1, py - 1);
          e.cen   = e.chk_c ? census_ref(px - 1, py - 1) : 0;
          e.pix   = img[py - 1][px - 1];
          e.last  = (px == W - 1) && (py == H - 1);
          exp_q.push_back(e);
        end
        if (px == 0 && py == 0) armed_m = 1'b1;
      end
    end
  end

  task automatic put(input int x, input int y, input int v);
    @(posedge clk);
    #1;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 10'(y);
    bus.pix_val   = 8'(v);
    bus.pix_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
    end
  endtask

  // rate 0: every cycle, 1: every other cycle; inj adds out-of-range strobes
  task automatic feed_rows(input int mode, input int y0, input int y1, input int rate, input bit inj);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < W; x++) begin
        put(x, y, pixf(mode, x, y));
        if (rate == 1) idle(1);
        if (inj && x == 160) begin
          put(W, y, 255);
          put(7, H, 0);
        end
      end
    end
  endtask

  initial begin
    vec_t vt[8];
    int   found, got;

    vt[0] = '{0, 0, 2,   1,  1, 8'h00};
    vt[1] = '{0, 0, 2, 318,  1, 8'h00};
    vt[2] = '{1, 0, 2,   1,  1, 8'h94};
    vt[3] = '{1, 0, 2, 255,  1, 8'hBD};
    vt[4] = '{1, 0, 2, 256,  1, 8'h00};
    vt[5] = '{1, 49, 51, 100, 50, 8'h94};
    vt[6] = '{2, 0, 3,   1,  1, 8'hE0};
    vt[7] = '{2, 0, 3, 200,  2, 8'hE0};

    seed          = $urandom;
    reset         = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_x     = 10'd0;
    bus.pix_y     = 10'd0;
    bus.pix_val   = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_census", int'(bus.census), 0);
    chk("rst_out_x", int'(bus.out_x), 0);
    chk("rst_out_y", int'(bus.out_y), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed vectors: feed a frame fragment, then probe one centre
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || vt[i].mode != vt[i-1].mode || vt[i].y0 != vt[i-1].y0) begin
        cap_q.delete();
        if (vt[i].y0 != 0) put(0, 0, pixf(vt[i].mode, 0, 0));
        feed_rows(vt[i].mode, vt[i].y0, vt[i].y1, 0, 1'b0);
        idle(4);
      end
      found = 0;
      got   = -1;
      foreach (cap_q[k])
        if (cap_q[k].x == vt[i].px && cap_q[k].y == vt[i].py) begin
          found = 1;
          got   = cap_q[k].c;
        end
      chk("vec_found", found, 1);
      chk("vec_census", got, vt[i].exp_c);
    end

    // Full constant frame: output count, first/last centre, single frame_done
    cap_q.delete();
    n_fd = 0;
    feed_rows(0, 0, H - 1, 0, 1'b0);
    idle(4);
    chk("frame_count", cap_q.size(), 75684);
    if (cap_q.size() > 0) begin
      chk("first_x", cap_q[0].x, 1);
      chk("first_y", cap_q[0].y, 1);
      chk("last_x", cap_q[cap_q.size()-1].x, W - 2);
      chk("last_y", cap_q[cap_q.size()-1].y, H - 2);
    end
    chk("fd_count", n_fd, 1);
    chk("fd_x", fd_x, W - 2);
    chk("fd_y", fd_y, H - 2);

    // Same random image at full rate and at half rate with dropped strobes
    cap_q.delete();
    feed_rows(3, 0, 2, 0, 1'b0);
    idle(4);
    cap_a = cap_q;
    cap_q.delete();
    feed_rows(3, 0, 2, 1, 1'b1);
    idle(4);
    cap_b = cap_q;
    chk("rate_count_a", cap_a.size(), W - 2);
    chk("rate_count_b", cap_b.size(), cap_a.size());
    for (int i = 0; i < cap_a.size() && i < cap_b.size(); i++) begin
      chk("rate_census", cap_b[i].c, cap_a[i].c);
      chk("rate_x", cap_b[i].x, cap_a[i].x);
      chk("rate_y", cap_b[i].y, cap_a[i].y);
    end

    // Reset mid-frame at input (150,120), resume at (151,120)
    put(0, 0, pixf(3, 0, 0));
    for (int x = 140; x < 150; x++) put(x, 120, pixf(3, x, 120));
    put(150, 120, pixf(3, 150, 120));
    reset = 1'b1;
    put(151, 120, pixf(3, 151, 120));
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_census", int'(bus.census), 0);
    chk("midrst_out_x", int'(bus.out_x), 0);
    cap_q.delete();
    for (int x = 152; x < W; x++) put(x, 120, pixf(3, x, 120));
    feed_rows(3, 121, 122, 0, 1'b0);
    idle(4);
    chk("post_reset_quiet", cap_q.size(), 0);
    feed_rows(3, 0, 2, 0, 1'b0);
    idle(4);
    chk("rearm_count", cap_q.size(), W - 2);
    if (cap_q.size() > 0) begin
      chk("rearm_first_x", cap_q[0].x, 1);
      chk("rearm_first_y", cap_q[0].y, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/census_3x3.md
Name: census_3x3

Overview:
- Streaming 3x3 census transform. Sits directly downstream of the camera pixel source (320x240, 8-bit grey, raster order, one pixel per valid strobe).
- Buffers two lines, forms a 3x3 window and emits an 8-bit census signature for every interior pixel.
- Feeds the left/right disparity matcher.

Parameters:
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pix_val  in  PIX_W  input pixel value
- pix_x  in  10  column of pix_val; valid in the same cycle as pix_valid
- pix_y  in  10  row of pix_val; valid in the same cycle as pix_valid
- pix_valid  in  1  input strobe; may be high every cycle or with gaps
- census  out  8  census signature of the window centre
- out_x  out  10  centre column
- out_y  out  10  centre row
- out_valid  out  1  one-cycle strobe qualifying census/out_x/out_y
- frame_done  out  1  one-cycle pulse with the last centre of a frame

Behaviour:
- Reset values: census=0, out_x=0, out_y=0, out_valid=0, frame_done=0, armed=0. Window registers are cleared. Line-buffer contents are don't-care.
- Accepted pixel: pix_valid=1 with pix_x<IMG_W and pix_y<IMG_H. Pixels with out-of-range coordinates are dropped: no buffer write, no window shift, no output.
- Line buffers: two IMG_W-deep, PIX_W-wide stores. LB0 holds row y-1 and LB1 holds row y-2, both indexed by x. On an accepted pixel at column x:
  - read LB0[x] and LB1[x];
  - write LB1[x]<=LB0[x] and LB0[x]<=pix_val.
  - Read-before-write at the same address is required.
- Window: 3 rows x 3 columns of shift registers, shifted by one column per accepted pixel. The new column is {LB1[x], LB0[x], pix_val}, top to bottom.
- Emission: an accepted pixel at (x,y) with x>=2, y>=2 and armed=1 yields centre (x-1, y-1). Centres cover x 1..IMG_W-2 and y 1..IMG_H-2: 318*238 = 75684 outputs per frame.
- Census bit set when neighbour < centre (unsigned; equal gives 0). Bit order:
  - bit7 top-left, bit6 top, bit5 top-right
  - bit4 left, bit3 right
  - bit2 bottom-left, bit1 bottom, bit0 bottom-right
- Latency: fixed 2 cycles from the accepting pix_valid edge to out_valid (stage 1 = buffer read/window shift, stage 2 = compare/register).
  - Back-to-back valids give back-to-back outputs; no stalls, no backpressure.
  - Gaps in pix_valid propagate as gaps in out_valid.
- frame_done: asserted in the same cycle as the out_valid for centre (IMG_W-2, IMG_H-2), i.e. from input (IMG_W-1, IMG_H-1).
- Arming:
  - armed sets on an accepted pixel at (0,0).
  - Before armed is set, pixels still write the buffers and window, but nothing is emitted.
  - Reset mid-frame clears armed and flushes the pipeline, so no out_valid or frame_done until the next frame start plus two full lines.
- Frame wrap from (IMG_W-1, IMG_H-1) to (0,0) needs no special handling. Stale buffer rows are never emitted, because emission requires y>=2.
- Coordinates are trusted; no discontinuity checking is done within a frame.

Optional Feature:
- Macro CENSUS_CENTER_EN.
- When defined: adds output port out_pix (PIX_W bits, out), the raw centre pixel aligned with out_valid. It resets to 0 and is used by hybrid SAD+census cost.
- When undefined: the port is absent and the other behaviour is identical.

Test Plan:
- Constant image (all 0x80), continuous valid -> exactly 75684 out_valid pulses; every census = 0x00; first output (1,1), last output (318,238) with frame_done=1 in that cycle only.
- Horizontal ramp pix_val = x & 0xFF -> census = 0x94 for all centres with x<=254, checked at (1,1) and (100,50).
- Vertical ramp pix_val = y -> census = 0xE0 for all centres; out_valid lags the accepting pix_valid by exactly 2 cycles.
- Source strobing valid every other cycle (camera rate) vs every cycle, with the same image -> identical census/out_x/out_y sequences; out_valid spacing follows the input spacing.
- Inject pix_valid with pix_x=320 and with pix_y=240 mid-line -> no output, no buffer corruption; subsequent census values match the reference model.
- Assert reset at input (150,120), release, resume feeding at (151,120) -> no out_valid until the next frame; after (0,0), the first output is at centre (1,1) on input (2,2).
